// File: rtl/lut_cam.sv
// Small content-addressable lookup table: registered lookup with a one-deep response stage.
// Optional saturating hit counter output when LUT_CAM_HITCNT_EN is defined.
module lut_cam #(
    parameter int NR = 4,
    parameter int KW = 4,
    parameter int DW = 8,
    parameter int CW = 8,
    localparam int IW = ($clog2(NR) < 1) ? 1 : $clog2(NR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [KW-1:0] wr_key,
    input  logic [DW-1:0] wr_val,
    input  logic          req_valid,
    input  logic [KW-1:0] req_key,
    output logic          req_ready,
    input  logic [DW-1:0] def,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_hit,
    output logic [IW-1:0] resp_idx
`ifdef LUT_CAM_HITCNT_EN
    ,
    output logic [CW-1:0] hit_cnt
`endif
);

    logic [NR-1:0] valid_q;
    logic [NR-1:0] valid_d;
    logic [KW-1:0] key_q [NR];
    logic [DW-1:0] val_q [NR];

    logic [NR-1:0] match_s;
    logic          hit_s;
    logic [IW-1:0] idx_s;
    logic [DW-1:0] data_s;
    logic          accept_s;
    logic          we_s;

    logic          resp_valid_q;
    logic          resp_valid_d;
    logic          resp_hit_q;
    logic          resp_hit_d;
    logic [IW-1:0] resp_idx_q;
    logic [IW-1:0] resp_idx_d;
    logic [DW-1:0] resp_data_q;
    logic [DW-1:0] resp_data_d;

    assign req_ready  = !resp_valid_q || resp_ready;
    assign accept_s   = req_valid && req_ready;
    assign we_s       = wr_en && !clr;

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_idx   = resp_idx_q;
    assign resp_data  = resp_data_q;

    // Priority match: scanning from the top down lets the lowest matching index win.
    always_comb begin
        match_s = {NR{1'b0}};
        hit_s   = 1'b0;
        idx_s   = {IW{1'b0}};
        data_s  = def;
        for (int i = NR - 1; i >= 0; i--) begin
            match_s[i] = valid_q[i] && (key_q[i] == req_key);
            hit_s      = match_s[i] ? 1'b1     : hit_s;
            idx_s      = match_s[i] ? IW'(i)   : idx_s;
            data_s     = match_s[i] ? val_q[i] : data_s;
        end
    end

    // Valid-bit next state; clr outranks writes, out-of-range indices match no entry.
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = {NR{1'b0}};
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (wr_en && (wr_idx == IW'(i))) begin
                    valid_d[i] = 1'b1;
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end
        end
    end

    // Response stage next state: load on acceptance, drop once consumed, else hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_hit_d   = resp_hit_q;
        resp_idx_d   = resp_idx_q;
        resp_data_d  = resp_data_q;
        if (accept_s) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = hit_s;
            resp_idx_d   = idx_s;
            resp_data_d  = data_s;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // Valid bits and response registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= {NR{1'b0}};
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= {IW{1'b0}};
            resp_data_q  <= {DW{1'b0}};
        end else begin
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_idx_q   <= resp_idx_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Key/value storage is left unreset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (we_s && (wr_idx == IW'(i))) begin
                key_q[i] <= wr_key;
                val_q[i] <= wr_val;
            end
        end
    end

`ifdef LUT_CAM_HITCNT_EN
    logic [CW-1:0] hit_cnt_q;
    logic [CW-1:0] hit_cnt_d;

    assign hit_cnt = hit_cnt_q;

    // Saturating count of registered hit responses; clr wins over an increment.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (clr) begin
            hit_cnt_d = {CW{1'b0}};
        end else if (accept_s && hit_s && (hit_cnt_q != {CW{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CW'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Hit counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= {CW{1'b0}};
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_lut_cam.sv
// Scoreboard bench for lut_cam: driver pushes expected responses, monitor pops on handshake.
// Define LUT_CAM_HITCNT_EN to also exercise the hit counter (built with CW=2).
module tb_lut_cam;
    localparam int NR = 4;
    localparam int KW = 4;
    localparam int DW = 8;
`ifdef LUT_CAM_HITCNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [KW-1:0] wr_key = '0;
    logic [DW-1:0] wr_val = '0;
    logic          req_valid = 1'b0;
    logic [KW-1:0] req_key = '0;
    logic          req_ready;
    logic [DW-1:0] def = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          resp_hit;
    logic [IW-1:0] resp_idx;
`ifdef LUT_CAM_HITCNT_EN
    logic [CW-1:0] hit_cnt;
`endif

    lut_cam #(.NR(NR), .KW(KW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_val(wr_val),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .def(def),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_hit(resp_hit), .resp_idx(resp_idx)
`ifdef LUT_CAM_HITCNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic hit;
        int   idx;
        int   data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference table: what the CAM should contain after each edge.
    logic m_valid [NR];
    int   m_key [NR];
    int   m_val [NR];
    int   m_cnt = 0;
    logic pend = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input logic we, input int wi, input int wk, input int wv, input logic c,
                       input logic rv, input int rk, input int d, input logic rr);
        logic acc;
        logic exp_rdy;
        exp_t e;
        wr_en = we; wr_idx = IW'(wi); wr_key = KW'(wk); wr_val = DW'(wv);
        clr = c; req_valid = rv; req_key = KW'(rk); def = DW'(d); resp_ready = rr;
        @(negedge clk);
        exp_rdy = !pend || rr;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        acc = rv && exp_rdy;
        e.hit = 1'b0; e.idx = 0; e.data = d & 8'hFF;
        for (int i = 0; i < NR; i++) begin
            if (!e.hit && m_valid[i] && m_key[i] == rk) begin
                e.hit = 1'b1; e.idx = i; e.data = m_val[i];
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            q.push_back(e);
            if (e.hit && m_cnt != (1 << CW) - 1) m_cnt++;
        end
        pend = acc ? 1'b1 : (rr ? 1'b0 : pend);
        if (c) begin
            for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
            m_cnt = 0;
        end else if (we && wi < NR) begin
            m_valid[wi] = 1'b1; m_key[wi] = wk; m_val[wi] = wv;
        end
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 8'hEE, rr);
    endtask

    task automatic req(input int rk, input int d, input logic rr);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, rk, d, rr);
    endtask

    task automatic wr(input int wi, input int wk, input int wv);
        cyc(1'b1, wi, wk, wv, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic model_reset();
        q.delete();
        pend = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
    endtask

    // Monitor: the presented response must match the queue head, and stay put while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
            if (resp_valid && q.size() != 0) begin
                chk("resp_hit", 32'(resp_hit), 32'(q[0].hit));
                chk("resp_idx", 32'(resp_idx), 32'(q[0].idx));
                chk("resp_data", 32'(resp_data), 32'(q[0].data));
                if (resp_ready) void'(q.pop_front());
            end
`ifdef LUT_CAM_HITCNT_EN
            chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
`endif
        end
    end

    initial begin
        model_reset();
        #3;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_resp_idx", 32'(resp_idx), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic hit.
        wr(0, 3, 8'hA5);
        req(3, 8'h00, 1'b1);
        idle(1'b1);
        // Duplicate keys: lowest index wins.
        wr(1, 7, 8'h11);
        wr(3, 7, 8'h22);
        req(7, 8'h00, 1'b1);
        idle(1'b1);
        // Miss returns def sampled at acceptance; def changes afterwards.
        req(9, 8'h3C, 1'b1);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 8'hFF, 1'b1);
        // Back-to-back with a three-cycle stall.
        req(3, 8'h01, 1'b1);
        repeat (3) req(7, 8'h02, 1'b0);
        req(7, 8'h02, 1'b1);
        req(9, 8'h44, 1'b1);
        req(3, 8'h45, 1'b1);
        idle(1'b1);
        // Same-edge write and lookup sees the old table.
        cyc(1'b1, 2, 5, 8'h77, 1'b0, 1'b1, 5, 8'h5A, 1'b1);
        req(5, 8'h5B, 1'b1);
        // clr beats wr_en; everything misses afterwards.
        cyc(1'b1, 0, 1, 8'h99, 1'b1, 1'b0, 0, 0, 1'b1);
        req(3, 8'h61, 1'b1);
        req(7, 8'h62, 1'b1);
        req(5, 8'h63, 1'b1);
        req(1, 8'h64, 1'b1);
        idle(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, NR - 1), $urandom_range(0, 7),
                $urandom_range(0, 255), $urandom_range(0, 49) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
                $urandom_range(0, 3) != 0);
        end
        idle(1'b1);
        idle(1'b1);

        // Reset while a response is stalled.
        wr(0, 4, 8'h4D);
        wr(1, 6, 8'h6D);
        req(4, 8'h00, 1'b0);
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_resp_data", 32'(resp_data), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        req(4, 8'h13, 1'b1);
        req(6, 8'h14, 1'b1);
        idle(1'b1);

`ifdef LUT_CAM_HITCNT_EN
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0, 1'b1);
        wr(0, 2, 8'h2A);
        repeat (5) req(2, 8'h00, 1'b1);
        idle(1'b1);
        chk("hit_cnt_sat", 32'(hit_cnt), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
